// File: rtl/counter_bank_pkg.sv
// Shared definitions for the counter bank.
// Arithmetic mode constants and select-width helper.
package counter_bank_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  function automatic int selw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/counter_bank_lane.sv
// One counter lane: priority mux, widened adder,
// clamp/wrap, sticky flags and threshold register.
module counter_bank_lane
  import counter_bank_pkg::*;
#(
  parameter int              width    = 8,
  parameter int              saturate = MODE_WRAP,
  parameter logic [width-1:0] init    = '0,
  parameter logic [width-1:0] thresh  = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] a,
  input  logic             add,
  input  logic [width-1:0] b,
  input  logic             sub,
  input  logic [width-1:0] c,
  input  logic             setc,
  input  logic [width-1:0] f,
  input  logic             setf,
  input  logic             clr,
  input  logic             clr_flags,
  output logic [width-1:0] q,
  output logic             ovf,
  output logic             udf,
  output logic             hit
);

  logic [width-1:0] base;
  logic [width-1:0] q_next;
  logic [width+1:0] sum;
  logic [width+1:0] a_ext;
  logic [width+1:0] b_ext;
  logic             over;
  logic             under;
  logic             set_ovf;
  logic             set_udf;

  // Two extra bits hold the full range
  // [-(2^w-1), 2*(2^w-1)] in two's complement.
  always_comb begin
    base  = setc ? c : (clr ? '0 : q);
    a_ext = add ? {2'b00, a} : '0;
    b_ext = sub ? {2'b00, b} : '0;
    sum   = {2'b00, base} + a_ext - b_ext;
    under = sum[width+1];
    over  = ~sum[width+1] & sum[width];
  end

  always_comb begin
    q_next  = sum[width-1:0];
    set_ovf = 1'b0;
    set_udf = 1'b0;
    unique case (1'b1)
      setf: q_next = f;
      over: begin
        set_ovf = 1'b1;
        if (saturate == MODE_SAT)
          q_next = '1;
      end
      under: begin
        set_udf = 1'b1;
        if (saturate == MODE_SAT)
          q_next = '0;
      end
      default: q_next = sum[width-1:0];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q   <= init;
      ovf <= 1'b0;
      udf <= 1'b0;
      hit <= (init == thresh);
    end else begin
      q   <= q_next;
      hit <= (q_next == thresh);
      if (clr_flags) begin
        ovf <= 1'b0;
        udf <= 1'b0;
      end else begin
        if (set_ovf) ovf <= 1'b1;
        if (set_udf) udf <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_bank.sv
// Bank of independent counters with a shared
// snapshot-and-clear read port.
module counter_bank
  import counter_bank_pkg::*;
#(
  parameter int               width    = 8,
  parameter int               nch      = 4,
  parameter logic [width-1:0] init     = '0,
  parameter int               saturate = MODE_WRAP,
  parameter logic [width-1:0] thresh   = '1,
  parameter int               SELW     = selw(nch)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [nch*width-1:0] DATA_A,
  input  logic [nch-1:0]       ADDA,
  input  logic [nch*width-1:0] DATA_B,
  input  logic [nch-1:0]       SUBB,
  input  logic [nch*width-1:0] DATA_C,
  input  logic [nch-1:0]       SETC,
  input  logic [nch*width-1:0] DATA_F,
  input  logic [nch-1:0]       SETF,
  input  logic                 RD_EN,
  input  logic [SELW-1:0]      RD_SEL,
  input  logic                 RD_CLR,
  input  logic                 CLR_FLAGS,
  output logic [nch*width-1:0] Q_OUT,
  output logic [width-1:0]     RD_DATA,
  output logic                 RD_VALID,
  output logic [nch-1:0]       OVF,
  output logic [nch-1:0]       UDF,
  output logic [nch-1:0]       HIT
);

  logic [nch-1:0]   sel;
  logic [nch-1:0]   clr;
  logic [width-1:0] snap;

  // Out-of-range selects match no lane: snapshot 0, no clear.
  always_comb begin
    snap = '0;
    sel  = '0;
    for (int i = 0; i < nch; i++) begin
      if (RD_SEL == SELW'(i)) begin
        sel[i] = 1'b1;
        snap   = Q_OUT[i*width +: width];
      end
    end
    clr = sel & {nch{RD_EN & RD_CLR}};
  end

  for (genvar i = 0; i < nch; i++) begin : g_lane
    counter_bank_lane #(
      .width    (width),
      .saturate (saturate),
      .init     (init),
      .thresh   (thresh)
    ) u_lane (
      .clk       (CLK),
      .rst       (RST),
      .a         (DATA_A[i*width +: width]),
      .add       (ADDA[i]),
      .b         (DATA_B[i*width +: width]),
      .sub       (SUBB[i]),
      .c         (DATA_C[i*width +: width]),
      .setc      (SETC[i]),
      .f         (DATA_F[i*width +: width]),
      .setf      (SETF[i]),
      .clr       (clr[i]),
      .clr_flags (CLR_FLAGS),
      .q         (Q_OUT[i*width +: width]),
      .ovf       (OVF[i]),
      .udf       (UDF[i]),
      .hit       (HIT[i])
    );
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RD_DATA  <= '0;
      RD_VALID <= 1'b0;
    end else begin
      RD_VALID <= RD_EN;
      if (RD_EN)
        RD_DATA <= snap;
    end
  end

endmodule

// File: tb/tb_counter_bank.sv
// Directed bench: wrap bank (thresh 0x05, 3-bit select)
// and saturating bank sharing one stimulus bus.
module tb_counter_bank;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] DATA_A, DATA_B, DATA_C, DATA_F;
  logic [3:0]  ADDA, SUBB, SETC, SETF;
  logic        RD_EN, RD_CLR, CLR_FLAGS;
  logic [2:0]  RD_SEL;

  logic [31:0] q_w, q_s;
  logic [7:0]  rd_w, rd_s;
  logic        rv_w, rv_s;
  logic [3:0]  ovf_w, udf_w, hit_w;
  logic [3:0]  ovf_s, udf_s, hit_s;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  counter_bank #(
    .width(8), .nch(4), .init(8'h00),
    .saturate(0), .thresh(8'h05), .SELW(3)
  ) u_wrap (
    .CLK(CLK), .RST(RST),
    .DATA_A(DATA_A), .ADDA(ADDA),
    .DATA_B(DATA_B), .SUBB(SUBB),
    .DATA_C(DATA_C), .SETC(SETC),
    .DATA_F(DATA_F), .SETF(SETF),
    .RD_EN(RD_EN), .RD_SEL(RD_SEL),
    .RD_CLR(RD_CLR), .CLR_FLAGS(CLR_FLAGS),
    .Q_OUT(q_w), .RD_DATA(rd_w),
    .RD_VALID(rv_w), .OVF(ovf_w),
    .UDF(udf_w), .HIT(hit_w)
  );

  counter_bank #(
    .width(8), .nch(4), .init(8'h00),
    .saturate(1), .thresh(8'hFF)
  ) u_sat (
    .CLK(CLK), .RST(RST),
    .DATA_A(DATA_A), .ADDA(ADDA),
    .DATA_B(DATA_B), .SUBB(SUBB),
    .DATA_C(DATA_C), .SETC(SETC),
    .DATA_F(DATA_F), .SETF(SETF),
    .RD_EN(RD_EN), .RD_SEL(RD_SEL[1:0]),
    .RD_CLR(RD_CLR), .CLR_FLAGS(CLR_FLAGS),
    .Q_OUT(q_s), .RD_DATA(rd_s),
    .RD_VALID(rv_s), .OVF(ovf_s),
    .UDF(udf_s), .HIT(hit_s)
  );

  typedef struct {
    int         lane;
    logic       setf; logic [7:0] f;
    logic       setc; logic [7:0] c;
    logic       adda; logic [7:0] a;
    logic       subb; logic [7:0] b;
    logic       rd_en; logic rd_clr;
    logic [2:0] rd_sel;
    logic       clrf;
    logic [7:0] eq;
    logic       eovf; logic eudf;
    logic       erv;  logic [7:0] erd;
  } vec_t;

  vec_t tbl[12];

  function automatic vec_t mk(
    input int l,
    input logic sf, input logic [7:0] f,
    input logic sc, input logic [7:0] c,
    input logic ad, input logic [7:0] a,
    input logic sb, input logic [7:0] b,
    input logic re, input logic rc,
    input logic [2:0] rs, input logic cf,
    input logic [7:0] eq, input logic eo,
    input logic eu, input logic ev,
    input logic [7:0] ed);
    vec_t v;
    v.lane = l; v.setf = sf; v.f = f;
    v.setc = sc; v.c = c;
    v.adda = ad; v.a = a;
    v.subb = sb; v.b = b;
    v.rd_en = re; v.rd_clr = rc;
    v.rd_sel = rs; v.clrf = cf;
    v.eq = eq; v.eovf = eo; v.eudf = eu;
    v.erv = ev; v.erd = ed;
    return v;
  endfunction

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic idle();
    DATA_A = '0; DATA_B = '0;
    DATA_C = '0; DATA_F = '0;
    ADDA = '0; SUBB = '0;
    SETC = '0; SETF = '0;
    RD_EN = 0; RD_CLR = 0;
    RD_SEL = '0; CLR_FLAGS = 0;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    idle();
    RST = 1;
    step();
    RST = 0;
    step();
  endtask

  task automatic lane_op(input int l,
                         input logic sf, input logic [7:0] f,
                         input logic ad, input logic [7:0] a,
                         input logic sb, input logic [7:0] b);
    idle();
    SETF[l] = sf; DATA_F[l*8 +: 8] = f;
    ADDA[l] = ad; DATA_A[l*8 +: 8] = a;
    SUBB[l] = sb; DATA_B[l*8 +: 8] = b;
    step();
  endtask

  initial begin
    RST = 0;
    idle();
    #2 RST = 1;
    #1;
    check("reset_q", q_w, 32'h0);
    check("reset_hit_sat", {28'h0, hit_s}, 32'h0);
    RST = 0;
    step();

    // async reset in the middle of counting with a snapshot pending
    lane_op(0, 1, 8'h30, 0, 0, 0, 0);
    lane_op(0, 0, 0, 1, 8'h01, 0, 0);
    idle();
    SUBB = 4'hF; DATA_B = 32'h0505_0505;
    RD_EN = 1;
    step();
    check("pre_reset_valid", {31'h0, rv_w}, 32'h1);
    check("pre_reset_udf", {28'h0, udf_w}, 32'hE);
    #2 RST = 1;
    #1;
    check("mid_reset_q", q_w, 32'h0);
    check("mid_reset_valid", {31'h0, rv_w}, 32'h0);
    check("mid_reset_flags",
          {24'h0, ovf_w, udf_w}, 32'h0);
    check("mid_reset_qsat", q_s, 32'h0);
    idle();
    step();
    RST = 0;
    step();

    // saturating bank, lane 1
    lane_op(1, 1, 8'h02, 0, 0, 0, 0);
    lane_op(1, 0, 0, 0, 0, 1, 8'h05);
    check("sat_udf_q", q_s[15:8], 8'h00);
    check("sat_udf_flag", {31'h0, udf_s[1]}, 32'h1);
    lane_op(1, 0, 0, 1, 8'hFF, 0, 0);
    check("sat_max_q", q_s[15:8], 8'hFF);
    check("sat_max_hit", {28'h0, hit_s}, 32'h2);
    check("sat_max_noovf", {31'h0, ovf_s[1]}, 32'h0);
    lane_op(1, 0, 0, 1, 8'h01, 0, 0);
    check("sat_ovf_q", q_s[15:8], 8'hFF);
    check("sat_ovf_flag", {31'h0, ovf_s[1]}, 32'h1);

    do_reset();

    tbl[0]  = mk(0, 1,8'hFE, 0,0, 0,0, 0,0, 0,0,3'd0, 0,
                 8'hFE, 0,0, 0,8'h00);
    tbl[1]  = mk(0, 0,0, 0,0, 1,8'h03, 0,0, 0,0,3'd0, 0,
                 8'h01, 1,0, 0,8'h00);
    tbl[2]  = mk(0, 0,0, 0,0, 0,0, 0,0, 0,0,3'd0, 0,
                 8'h01, 1,0, 0,8'h00);
    tbl[3]  = mk(0, 0,0, 0,0, 0,0, 0,0, 0,0,3'd0, 1,
                 8'h01, 0,0, 0,8'h00);
    tbl[4]  = mk(2, 1,8'h10, 0,0, 0,0, 0,0, 0,0,3'd0, 0,
                 8'h10, 0,0, 0,8'h00);
    tbl[5]  = mk(2, 0,0, 0,0, 1,8'h03, 0,0, 1,1,3'd2, 0,
                 8'h03, 0,0, 1,8'h10);
    tbl[6]  = mk(3, 1,8'h40, 1,8'h20, 1,8'h01, 0,0, 0,0,3'd0, 0,
                 8'h40, 0,0, 0,8'h00);
    tbl[7]  = mk(3, 0,0, 1,8'h20, 1,8'h01, 0,0, 0,0,3'd0, 0,
                 8'h21, 0,0, 0,8'h00);
    tbl[8]  = mk(1, 0,0, 0,0, 0,0, 1,8'h05, 0,0,3'd0, 0,
                 8'hFB, 0,1, 0,8'h00);
    tbl[9]  = mk(1, 0,0, 0,0, 0,0, 0,0, 1,1,3'd7, 0,
                 8'hFB, 0,1, 1,8'h00);
    tbl[10] = mk(1, 0,0, 0,0, 0,0, 0,0, 1,0,3'd1, 0,
                 8'hFB, 0,1, 1,8'hFB);
    tbl[11] = mk(0, 0,0, 1,8'h00, 0,0, 1,8'h01, 0,0,3'd0, 0,
                 8'hFF, 0,1, 0,8'h00);

    for (int i = 0; i < 12; i++) begin
      int l;
      l = tbl[i].lane;
      idle();
      SETF[l] = tbl[i].setf; DATA_F[l*8 +: 8] = tbl[i].f;
      SETC[l] = tbl[i].setc; DATA_C[l*8 +: 8] = tbl[i].c;
      ADDA[l] = tbl[i].adda; DATA_A[l*8 +: 8] = tbl[i].a;
      SUBB[l] = tbl[i].subb; DATA_B[l*8 +: 8] = tbl[i].b;
      RD_EN = tbl[i].rd_en; RD_CLR = tbl[i].rd_clr;
      RD_SEL = tbl[i].rd_sel; CLR_FLAGS = tbl[i].clrf;
      step();
      check($sformatf("v%0d_q", i),
            {24'h0, q_w[l*8 +: 8]}, {24'h0, tbl[i].eq});
      check($sformatf("v%0d_ovf", i),
            {31'h0, ovf_w[l]}, {31'h0, tbl[i].eovf});
      check($sformatf("v%0d_udf", i),
            {31'h0, udf_w[l]}, {31'h0, tbl[i].eudf});
      check($sformatf("v%0d_rv", i),
            {31'h0, rv_w}, {31'h0, tbl[i].erv});
      if (tbl[i].erv)
        check($sformatf("v%0d_rd", i),
              {24'h0, rd_w}, {24'h0, tbl[i].erd});
    end
    check("tbl_final_q", q_w, 32'h21_03_FB_FF);

    do_reset();

    // HIT on wrap bank, thresh 0x05
    lane_op(0, 1, 8'h03, 0, 0, 0, 0);
    check("hit_q3", {28'h0, hit_w}, 32'h0);
    lane_op(0, 0, 0, 1, 8'h01, 0, 0);
    check("hit_q4", {28'h0, hit_w}, 32'h0);
    lane_op(0, 0, 0, 1, 8'h01, 0, 0);
    check("hit_q5_val", {24'h0, q_w[7:0]}, 32'h05);
    check("hit_q5", {28'h0, hit_w}, 32'h1);
    lane_op(0, 0, 0, 1, 8'h01, 0, 0);
    check("hit_q6", {28'h0, hit_w}, 32'h0);
    check("hit_q6_val", {24'h0, q_w[7:0]}, 32'h06);

    idle();
    step();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
